// File: rtl/if_id_stage.sv
// Fetch PC and IF/ID register with IRQ entry, branch redirect and load-use stall; registered outputs, 1-cycle latency.
// Backpressure: PC_IFWrite=0 freezes PC_if and IF/ID (except an IRQ take) and counts stall cycles.
module if_id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_IFWrite,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        IRQ,
    input  logic [31:0] Instr_in,
    output logic [31:0] PC_if,
    output logic        PC_31,
    output logic [31:0] PC_id,
    output logic        PC_id_31,
    output logic [31:0] Instr_id,
    output logic        Valid_id,
    output logic [31:0] Xp,
    output logic        Irq_ack,
    output logic [15:0] Stall_Count
);

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    logic        irq_take;
    logic        do_branch;
    logic        do_stall;
    logic [31:0] pc_seq;

    // Interrupts are masked while either stage is in kernel space, so the
    // handler entry itself can never be re-interrupted.
    assign irq_take  = IRQ && !PC_if[31] && !PC_id[31];
    assign do_branch = Branch_Taken && PC_IFWrite;
    assign do_stall  = !PC_IFWrite;
    assign pc_seq    = {PC_if[31], PC_if[30:0] + 31'd4};

    assign PC_31    = PC_if[31];
    assign PC_id_31 = PC_id[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_if       <= RESET_PC;
            PC_id       <= RESET_PC;
            Instr_id    <= NOP;
            Valid_id    <= 1'b0;
            Xp          <= 32'h0000_0000;
            Irq_ack     <= 1'b0;
            Stall_Count <= 16'h0000;
        end else begin
            Irq_ack <= irq_take;
            if (irq_take) begin
                PC_if    <= IRQ_VECTOR;
                PC_id    <= PC_if;
                Instr_id <= NOP;
                Valid_id <= 1'b0;
                Xp       <= Valid_id ? PC_id : PC_if;
            end else if (do_branch) begin
                PC_if    <= Branch_Target;
                PC_id    <= PC_if;
                Instr_id <= NOP;
                Valid_id <= 1'b0;
            end else if (do_stall) begin
                // A branch seen during a stall is dropped; ID re-resolves it.
                if (Stall_Count != 16'hFFFF) begin
                    Stall_Count <= Stall_Count + 16'd1;
                end
            end else begin
                PC_if    <= pc_seq;
                PC_id    <= PC_if;
                Instr_id <= Instr_in;
                Valid_id <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, saturation/reset sequences, randomized run vs reference model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_IFWrite;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        IRQ;
    logic [31:0] Instr_in;
    logic [31:0] PC_if;
    logic        PC_31;
    logic [31:0] PC_id;
    logic        PC_id_31;
    logic [31:0] Instr_id;
    logic        Valid_id;
    logic [31:0] Xp;
    logic        Irq_ack;
    logic [15:0] Stall_Count;

    int total  = 0;
    int passed = 0;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .PC_IFWrite(PC_IFWrite), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .IRQ(IRQ), .Instr_in(Instr_in),
        .PC_if(PC_if), .PC_31(PC_31), .PC_id(PC_id), .PC_id_31(PC_id_31),
        .Instr_id(Instr_id), .Valid_id(Valid_id), .Xp(Xp), .Irq_ack(Irq_ack),
        .Stall_Count(Stall_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr, br;
        logic [31:0] tgt;
        logic        irq;
        logic [31:0] instr;
        logic [31:0] e_pc_if, e_pc_id, e_instr;
        logic        e_vld;
        logic [31:0] e_xp;
        logic        e_ack;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        longint unsigned pc_if, pc_id, instr, xp;
        bit              vld, ack;
        int              cnt;
    } mstate_t;

    vec_t    vecs[23];
    mstate_t m;

    function automatic vec_t mkv(logic wr, logic br, logic [31:0] tgt, logic irq, logic [31:0] instr,
                                 logic [31:0] pif, logic [31:0] pid, logic [31:0] ins, logic vld,
                                 logic [31:0] xp, logic ack, logic [15:0] cnt);
        vec_t v;
        v.wr = wr; v.br = br; v.tgt = tgt; v.irq = irq; v.instr = instr;
        v.e_pc_if = pif; v.e_pc_id = pid; v.e_instr = ins; v.e_vld = vld;
        v.e_xp = xp; v.e_ack = ack; v.e_cnt = cnt;
        return v;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.pc_if = 64'h8000_0000; s.pc_id = 64'h8000_0000; s.instr = 0; s.xp = 0;
        s.vld = 0; s.ack = 0; s.cnt = 0;
        return s;
    endfunction

    // Behaviour taken straight from the priority rules: interrupt, branch, stall, fetch.
    function automatic mstate_t model_step(mstate_t s, bit wr, bit br, longint unsigned tgt,
                                           bit irq, longint unsigned instr);
        mstate_t n = s;
        bit user_if = s.pc_if < 64'h8000_0000;
        bit user_id = s.pc_id < 64'h8000_0000;
        n.ack = 0;
        if (irq && user_if && user_id) begin
            n.pc_if = 64'h8000_0004; n.pc_id = s.pc_if; n.instr = 0; n.vld = 0;
            n.xp = s.vld ? s.pc_id : s.pc_if; n.ack = 1;
        end else if (wr && br) begin
            n.pc_if = tgt; n.pc_id = s.pc_if; n.instr = 0; n.vld = 0;
        end else if (!wr) begin
            n.cnt = (s.cnt >= 65535) ? 65535 : s.cnt + 1;
        end else begin
            longint unsigned half = 64'h8000_0000;
            n.pc_if = (s.pc_if / half) * half + ((s.pc_if % half) + 4) % half;
            n.pc_id = s.pc_if; n.instr = instr; n.vld = 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic wr, input logic br, input logic [31:0] tgt,
                         input logic irq, input logic [31:0] instr);
        PC_IFWrite = wr; Branch_Taken = br; Branch_Target = tgt; IRQ = irq; Instr_in = instr;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc_if"}, PC_if, 32'h8000_0000);
        chk({tag, ".pc_id"}, PC_id, 32'h8000_0000);
        chk({tag, ".instr"}, Instr_id, 32'h0);
        chk({tag, ".vld"}, {31'd0, Valid_id}, 32'd0);
        chk({tag, ".xp"}, Xp, 32'h0);
        chk({tag, ".ack"}, {31'd0, Irq_ack}, 32'd0);
        chk({tag, ".cnt"}, {16'd0, Stall_Count}, 32'd0);
    endtask

    task automatic chk_model();
        chk("rnd.pc_if", PC_if, m.pc_if[31:0]);
        chk("rnd.pc_31", {31'd0, PC_31}, {31'd0, m.pc_if >= 64'h8000_0000});
        chk("rnd.pc_id", PC_id, m.pc_id[31:0]);
        chk("rnd.pc_id_31", {31'd0, PC_id_31}, {31'd0, m.pc_id >= 64'h8000_0000});
        chk("rnd.instr", Instr_id, m.instr[31:0]);
        chk("rnd.vld", {31'd0, Valid_id}, {31'd0, m.vld});
        chk("rnd.xp", Xp, m.xp[31:0]);
        chk("rnd.ack", {31'd0, Irq_ack}, {31'd0, m.ack});
        chk("rnd.cnt", {16'd0, Stall_Count}, m.cnt);
    endtask

    initial begin
        //               wr br tgt           irq instr           pc_if         pc_id         instr_id      vld xp            ack cnt
        vecs[0]  = mkv(1, 0, 32'h0,        0, 32'h2001_0001, 32'h8000_0004, 32'h8000_0000, 32'h2001_0001, 1, 32'h0,   0, 16'd0);
        vecs[1]  = mkv(1, 1, 32'h0000_0100, 0, 32'h0,       32'h0000_0100, 32'h8000_0004, 32'h0,         0, 32'h0,   0, 16'd0);
        vecs[2]  = mkv(1, 0, 32'h0,        0, 32'hAAAA_0001, 32'h0000_0104, 32'h0000_0100, 32'hAAAA_0001, 1, 32'h0,   0, 16'd0);
        vecs[3]  = mkv(0, 0, 32'h0,        0, 32'h0,         32'h0000_0104, 32'h0000_0100, 32'hAAAA_0001, 1, 32'h0,   0, 16'd1);
        vecs[4]  = mkv(0, 0, 32'h0,        0, 32'h0,         32'h0000_0104, 32'h0000_0100, 32'hAAAA_0001, 1, 32'h0,   0, 16'd2);
        vecs[5]  = mkv(1, 0, 32'h0,        0, 32'hBBBB_0002, 32'h0000_0108, 32'h0000_0104, 32'hBBBB_0002, 1, 32'h0,   0, 16'd2);
        vecs[6]  = mkv(0, 1, 32'h0000_0400, 0, 32'h0,       32'h0000_0108, 32'h0000_0104, 32'hBBBB_0002, 1, 32'h0,   0, 16'd3);
        vecs[7]  = mkv(1, 1, 32'h0000_0400, 0, 32'h0,       32'h0000_0400, 32'h0000_0108, 32'h0,         0, 32'h0,   0, 16'd3);
        vecs[8]  = mkv(1, 0, 32'h0,        0, 32'hCCCC_0003, 32'h0000_0404, 32'h0000_0400, 32'hCCCC_0003, 1, 32'h0,   0, 16'd3);
        vecs[9]  = mkv(1, 1, 32'h0000_01FC, 0, 32'h0,       32'h0000_01FC, 32'h0000_0404, 32'h0,         0, 32'h0,   0, 16'd3);
        vecs[10] = mkv(1, 0, 32'h0,        0, 32'hDDDD_0004, 32'h0000_0200, 32'h0000_01FC, 32'hDDDD_0004, 1, 32'h0,   0, 16'd3);
        vecs[11] = mkv(0, 0, 32'h0,        1, 32'h0,         32'h8000_0004, 32'h0000_0200, 32'h0,         0, 32'h1FC, 1, 16'd3);
        vecs[12] = mkv(1, 0, 32'h0,        1, 32'hEEEE_0005, 32'h8000_0008, 32'h8000_0004, 32'hEEEE_0005, 1, 32'h1FC, 0, 16'd3);
        vecs[13] = mkv(1, 0, 32'h0,        1, 32'h1,         32'h8000_000C, 32'h8000_0008, 32'h1,         1, 32'h1FC, 0, 16'd3);
        vecs[14] = mkv(1, 0, 32'h0,        1, 32'h2,         32'h8000_0010, 32'h8000_000C, 32'h2,         1, 32'h1FC, 0, 16'd3);
        vecs[15] = mkv(1, 0, 32'h0,        1, 32'h3,         32'h8000_0014, 32'h8000_0010, 32'h3,         1, 32'h1FC, 0, 16'd3);
        vecs[16] = mkv(1, 1, 32'h0000_0300, 0, 32'h0,       32'h0000_0300, 32'h8000_0014, 32'h0,         0, 32'h1FC, 0, 16'd3);
        vecs[17] = mkv(1, 1, 32'h0000_0500, 0, 32'h0,       32'h0000_0500, 32'h0000_0300, 32'h0,         0, 32'h1FC, 0, 16'd3);
        vecs[18] = mkv(1, 0, 32'h0,        1, 32'h9,         32'h8000_0004, 32'h0000_0500, 32'h0,         0, 32'h500, 1, 16'd3);
        vecs[19] = mkv(1, 1, 32'h7FFF_FFFC, 0, 32'h0,       32'h7FFF_FFFC, 32'h8000_0004, 32'h0,         0, 32'h500, 0, 16'd3);
        vecs[20] = mkv(1, 0, 32'h0,        0, 32'h3,         32'h0000_0000, 32'h7FFF_FFFC, 32'h3,         1, 32'h500, 0, 16'd3);
        vecs[21] = mkv(1, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'hFFFF_FFFC, 32'h0000_0000, 32'h0,         0, 32'h500, 0, 16'd3);
        vecs[22] = mkv(1, 0, 32'h0,        0, 32'h4,         32'h8000_0000, 32'hFFFF_FFFC, 32'h4,         1, 32'h500, 0, 16'd3);

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0);
        cycle();
        cycle();
        chk_reset_vals("reset");

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].br, vecs[i].tgt, vecs[i].irq, vecs[i].instr);
            cycle();
            chk($sformatf("vec%0d.pc_if", i), PC_if, vecs[i].e_pc_if);
            chk($sformatf("vec%0d.pc_id", i), PC_id, vecs[i].e_pc_id);
            chk($sformatf("vec%0d.instr", i), Instr_id, vecs[i].e_instr);
            chk($sformatf("vec%0d.vld", i), {31'd0, Valid_id}, {31'd0, vecs[i].e_vld});
            chk($sformatf("vec%0d.xp", i), Xp, vecs[i].e_xp);
            chk($sformatf("vec%0d.ack", i), {31'd0, Irq_ack}, {31'd0, vecs[i].e_ack});
            chk($sformatf("vec%0d.cnt", i), {16'd0, Stall_Count}, {16'd0, vecs[i].e_cnt});
            chk($sformatf("vec%0d.pc_31", i), {31'd0, PC_31}, {31'd0, vecs[i].e_pc_if[31]});
        end

        // Saturation: count is 3 here; 65531 more stalls reach 0xFFFE.
        drive(0, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 65531; k++) cycle();
        chk("sat.fffe", {16'd0, Stall_Count}, 32'h0000_FFFE);
        cycle();
        chk("sat.ffff", {16'd0, Stall_Count}, 32'h0000_FFFF);
        for (int k = 0; k < 8; k++) cycle();
        chk("sat.hold", {16'd0, Stall_Count}, 32'h0000_FFFF);
        chk("sat.pc_if", PC_if, 32'h8000_0000);

        // Asynchronous reset in the middle of a stall.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("arst");
        cycle();
        drive(1, 0, 32'h0, 0, 32'h1234_5678);
        rst_n = 1'b1;
        cycle();
        chk("first.pc_if", PC_if, 32'h8000_0004);
        chk("first.pc_id", PC_id, 32'h8000_0000);
        chk("first.instr", Instr_id, 32'h1234_5678);
        chk("first.vld", {31'd0, Valid_id}, 32'd1);

        // Reset asserted while a branch is being presented.
        drive(1, 1, 32'h0000_0800, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("arst_br");
        cycle();
        drive(0, 0, 32'h0, 0, 32'h0);
        rst_n = 1'b1;
        m = model_reset();

        for (int k = 0; k < 3000; k++) begin
            logic        wr, br, irq;
            logic [31:0] tgt, ins;
            wr  = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 7) == 0);
            irq = ($urandom_range(0, 5) == 0);
            tgt = {$urandom_range(0, 1) == 1, 31'($urandom) & 31'h7FFF_FFFC};
            if ($urandom_range(0, 15) == 0) tgt = 32'h7FFF_FFF8;
            ins = $urandom;
            drive(wr, br, tgt, irq, ins);
            m = model_step(m, wr, br, tgt, irq, ins);
            cycle();
            chk_model();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
